alu_seq: RTL
============

Name: alu_seq

Overview:
- Parametrised, registered successor to the 8-bit combinational ALU, with the same 16-op `sel` encoding.
- Adds a valid/ready handshake on input and output, a status-flag output and an iterative shift-add multiply.
- Sits between the operand register file and the result writeback path, one operation in flight at a time.

Parameters:
WIDTH, 8, operand/result width in bits (min 4)
CNT_W, $clog2(WIDTH)+1, width of multiply bit counter (derived, do not override)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous assert, active-low
a  input  WIDTH  operand A
b  input  WIDTH  operand B
sel  input  4  operation select
in_valid  input  1  operands/sel valid
in_ready  output  1  block can accept an operation
z  output  WIDTH  registered result
flags  output  4  {cout, ovf, neg, zero}, registered with z
err  output  1  unsupported op executed (see Optional Feature)
out_valid  output  1  z/flags/err valid
out_ready  input  1  consumer takes result

Behaviour:
- One clock domain; rst_n is asynchronous, active-low.
- Reset values: z=0, flags=0, err=0, out_valid=0, in_ready=1, state=IDLE, counter=0.
- Op encoding:
  - 0 ADD, 1 SUB (a-b), 2 AND, 3 OR, 4 XOR, 5 NOT a, 6 NAND, 7 NOR
  - 8 XNOR, 9 SHL a by 1, 10 SHR logical a by 1, 11 ASR a by 1
  - 12 ROL a by 1, 13 ROR a by 1, 14 INC a, 15 MUL (low WIDTH bits of unsigned a*b)
- FSM states: IDLE, BUSY, DONE. in_ready = (state==IDLE). out_valid = (state==DONE).
- Accept: in_valid & in_ready at a rising edge latches a, b, sel.
- Ops 0-14: the result is computed and registered on the accept edge; state goes to DONE.
  - out_valid is high in the cycle after the accept cycle (latency 1).
- Op 15: the accept edge goes to BUSY and clears the counter and the 2*WIDTH-bit product.
  - Each BUSY edge processes one multiplier bit, LSB first.
  - After WIDTH BUSY edges the state goes to DONE; out_valid appears WIDTH+1 cycles after the accept cycle.
- DONE: z/flags/err hold stable until out_valid & out_ready at an edge, which goes to IDLE.
  - No new accept is possible in the same cycle (no bypass); max throughput is 1 op per 2 cycles.
- Inputs a/b/sel are ignored outside the accept edge. Changing them during BUSY/DONE has no effect.
- Arithmetic is unsigned modulo 2^WIDTH; ovf uses two's-complement interpretation.
- cout:
  - ADD: carry out.
  - SUB: borrow (1 iff a<b unsigned).
  - INC: carry out (a all ones).
  - SHL/ROL: old a[WIDTH-1]. SHR/ASR/ROR: old a[0].
  - All others: 0.
- ovf:
  - ADD/SUB/INC: signed overflow.
  - MUL: 1 iff the upper WIDTH product bits are nonzero.
  - All others: 0.
- neg = z[WIDTH-1]; zero = (z==0).
- Reset mid-operation (any state): immediate return to reset values; any in-flight op and held result are discarded.
- out_ready held high while IDLE/BUSY has no effect.

Optional Feature:
- Macro ALU_MUL_EN.
- Defined: op 15 runs the iterative multiply described above, and err is always 0.
- Not defined: the multiplier datapath and counter are not built. Op 15 behaves as a single-cycle op returning z=0 and flags=4'b0001 (zero only) with err=1; BUSY is unreachable.
- err is cleared on the next accept.

Test Plan:
- WIDTH=8, ADD a=0x7F b=0x01 -> one cycle later out_valid=1, z=0x80, flags cout=0 ovf=1 neg=1 zero=0.
- SUB a=0x01 b=0x02 -> z=0xFF, cout=1, ovf=0, neg=1. Then INC a=0xFF -> z=0x00, cout=1, zero=1.
- Shifts on a=0x81: SHL -> 0x02 cout=1; SHR -> 0x40 cout=1; ASR -> 0xC0; ROL -> 0x03; ROR -> 0xC0 cout=1.
- ALU_MUL_EN defined:
  - MUL a=0x0F b=0x11 -> z=0xFF, ovf=0, out_valid exactly 9 cycles after the accept cycle, in_ready=0 throughout.
  - MUL a=0x10 b=0x10 -> z=0x00, ovf=1, zero=1.
- Backpressure: ADD 3+4 with out_ready low for 5 cycles -> z=0x07 held, out_valid=1, in_ready=0. Raise out_ready -> IDLE next cycle, in_ready=1. in_valid held high meanwhile is not accepted early.
- Reset and disabled multiply:
  - Start MUL, assert rst_n low mid-BUSY (cycle 4) -> all outputs immediately at reset values. After release, ADD 1+1 -> z=0x02 with normal latency.
  - ALU_MUL_EN undefined: MUL -> latency 1, z=0, err=1.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: registered, handshaked ALU with a 16-op select encoding.
//
// Accepts one operation at a time on a valid/ready handshake, registers the
// result together with status flags, and holds it until the consumer takes it.
// Ops 0-14 complete in one cycle. Op 15 (MUL) is an iterative shift-add
// multiply that takes WIDTH busy cycles when the ALU_MUL_EN macro is defined.
// With ALU_MUL_EN undefined, op 15 is a single-cycle op that returns zero and
// raises err.
//
// Parameters:
//   WIDTH      operand/result width in bits (min 4)
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous, active-low reset
//   a, b       operands (sampled only on the accept edge)
//   sel        operation select (sampled only on the accept edge)
//   in_valid   operands/sel valid
//   in_ready   block is idle and can accept an operation
//   z          registered result
//   flags      {cout, ovf, neg, zero}, registered with z
//   err        unsupported op was executed
//   out_valid  z/flags/err valid
//   out_ready  consumer takes the result
//
// Configuration macro: ALU_MUL_EN (enables the iterative multiplier).

module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] z,
  output logic [3:0]       flags,
  output logic             err,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_NAND = 4'd6;
  localparam logic [3:0] OP_NOR  = 4'd7;
  localparam logic [3:0] OP_XNOR = 4'd8;
  localparam logic [3:0] OP_SHL  = 4'd9;
  localparam logic [3:0] OP_SHR  = 4'd10;
  localparam logic [3:0] OP_ASR  = 4'd11;
  localparam logic [3:0] OP_ROL  = 4'd12;
  localparam logic [3:0] OP_ROR  = 4'd13;
  localparam logic [3:0] OP_INC  = 4'd14;
  localparam logic [3:0] OP_MUL  = 4'd15;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, next_state;
  logic             accept;
  logic             is_mul;
  logic [WIDTH-1:0] res;
  logic             res_cout, res_ovf;
  logic [WIDTH:0]   ext;
  logic [3:0]       alu_flags;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;

  // Single-cycle datapath, evaluated straight from the inputs so the result
  // can be registered on the accept edge itself. Op 15 falls to the default
  // arm, which yields z=0 and flags=zero-only.
  always_comb begin
    ext      = '0;
    res      = '0;
    res_cout = 1'b0;
    res_ovf  = 1'b0;
    case (sel)
      OP_ADD: begin
        ext      = {1'b0, a} + {1'b0, b};
        res      = ext[WIDTH-1:0];
        res_cout = ext[WIDTH];
        res_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        // The extra top bit of the widened difference is the borrow.
        ext      = {1'b0, a} - {1'b0, b};
        res      = ext[WIDTH-1:0];
        res_cout = ext[WIDTH];
        res_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NOT:  res = ~a;
      OP_NAND: res = ~(a & b);
      OP_NOR:  res = ~(a | b);
      OP_XNOR: res = ~(a ^ b);
      OP_SHL: begin
        res      = {a[WIDTH-2:0], 1'b0};
        res_cout = a[WIDTH-1];
      end
      OP_SHR: begin
        res      = {1'b0, a[WIDTH-1:1]};
        res_cout = a[0];
      end
      OP_ASR: begin
        res      = {a[WIDTH-1], a[WIDTH-1:1]};
        res_cout = a[0];
      end
      OP_ROL: begin
        res      = {a[WIDTH-2:0], a[WIDTH-1]};
        res_cout = a[WIDTH-1];
      end
      OP_ROR: begin
        res      = {a[0], a[WIDTH-1:1]};
        res_cout = a[0];
      end
      OP_INC: begin
        ext      = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};
        res      = ext[WIDTH-1:0];
        res_cout = ext[WIDTH];
        res_ovf  = ~a[WIDTH-1] & res[WIDTH-1];
      end
      default: res = '0;
    endcase
  end

  assign alu_flags = {res_cout, res_ovf, res[WIDTH-1], (res == '0)};

`ifdef ALU_MUL_EN
  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc, acc_next, mcand;
  logic [WIDTH-1:0]   mplier;
  logic               last_bit;

  assign is_mul   = (sel == OP_MUL);
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  // One shift-add step: add the shifted multiplicand when the current
  // multiplier LSB is set.
  always_comb begin
    acc_next = acc;
    if (mplier[0]) acc_next = acc + mcand;
  end

  // Multiplier state: loaded on accept, advanced once per BUSY edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (accept && is_mul) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
    end else if (state == BUSY) begin
      cnt    <= cnt + CNT_W'(1);
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end
`else
  assign is_mul = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic. DONE only releases on a consumer handshake, and IDLE is
  // only re-entered from DONE, so there is no same-cycle bypass.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (in_valid) next_state = is_mul ? BUSY : DONE;
`ifdef ALU_MUL_EN
      BUSY: if (last_bit) next_state = DONE;
`else
      BUSY: next_state = IDLE;
`endif
      DONE: if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Result registers: written on accept for single-cycle ops, or on the final
  // multiply step, and otherwise held so DONE presents a stable result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z     <= '0;
      flags <= '0;
      err   <= 1'b0;
    end else if (accept) begin
`ifdef ALU_MUL_EN
      err <= 1'b0;
      if (!is_mul) begin
        z     <= res;
        flags <= alu_flags;
      end
`else
      // Without the multiplier, op 15 takes the datapath default (z=0,
      // zero flag only) and is reported as unsupported.
      err   <= (sel == OP_MUL);
      z     <= res;
      flags <= alu_flags;
`endif
    end
`ifdef ALU_MUL_EN
    else if ((state == BUSY) && last_bit) begin
      z     <= acc_next[WIDTH-1:0];
      flags <= {1'b0, |acc_next[2*WIDTH-1:WIDTH], acc_next[WIDTH-1],
                (acc_next[WIDTH-1:0] == '0)};
    end
`endif
  end

endmodule
